romload_writer: RTL and testbench
=================================

# romload_writer

Downstream consumer of the IO subsystem's ROM-loading byte stream. Packs incoming bytes into big-endian 16-bit words and writes them into SDRAM through a request/acknowledge port. A small word FIFO absorbs SDRAM latency. The block selects the target region from the loading mode and reports the loaded byte count and completion to the core.

## Interface

Parameters:
- ROM_BASE, 22'h000000: word base address for mode 1 (cartridge ROM)
- CARTRAM_BASE, 22'h380000: word base address for mode 2 (cart RAM, byte 0x700000)
- BIOS_BASE, 22'h300000: word base address for mode 4 (BIOS)
- FIFO_DEPTH, 4: word FIFO entries, power of two, ≥2

Ports:
- clk  in  1  system clock, same domain as the byte stream
- resetn  in  1  synchronous, active-low reset (clock clk)
- rom_loading  in  3  0 idle, 1 ROM, 2 cart RAM, 3 config, 4 BIOS
- rom_do  in  8  stream byte
- rom_do_valid  in  1  one-cycle byte strobe, ≥2 cycles apart
- mem_req  out  1  write request, held until acked
- mem_ack  in  1  one-cycle acknowledge of current request
- mem_addr  out  22  word address
- mem_wdata  out  16  write data, first byte of pair in [15:8]
- mem_be  out  2  byte enables, [1]=high byte
- rom_size  out  23  bytes accepted in current/last session
- load_done  out  1  one-cycle pulse when a session is fully written
- overflow  out  1  sticky; a word was dropped because the FIFO was full

## Operation

- The FSM has three states: IDLE, LOAD, FLUSH.
- IDLE → LOAD when rom_loading ∈ {1,2,4}.
  - Latch the mode and set the write pointer to the mode's base.
  - Clear rom_size, the pending half-word and overflow.
- In mode 0, 3 or 5-7 the block stays in IDLE and ignores bytes.
- LOAD, byte handling:
  - Each rom_do_valid increments rom_size.
  - An even-index byte (rom_size[0]==0 before increment) is held in the high half.
  - An odd-index byte completes the word {hi, rom_do}, which is pushed to the FIFO with be=2'b11 and address=wptr. wptr then increments, wrapping modulo 2^22.
- If the FIFO is full at push, the word is dropped, wptr still increments, and overflow is set.
- LOAD → FLUSH when rom_loading differs from the latched mode. A mode change directly to another load mode also passes through FLUSH, and the new session starts from IDLE afterwards.
- FLUSH:
  - A pending odd final byte is pushed as {hi, 8'h00} with be=2'b10. If the FIFO is full, it waits and does not drop.
  - Bytes arriving in FLUSH are ignored.
  - When the FIFO is empty and no request is outstanding: pulse load_done and go to IDLE.
- Write port:
  - The FIFO head drives mem_addr/mem_wdata/mem_be, with mem_req=1 while the FIFO is non-empty.
  - The word is popped on mem_req&&mem_ack.
  - mem_req deasserts for at least the cycle after an ack, and the next entry is presented the following cycle.
  - Outputs are stable while mem_req=1.
- rom_size is 23 bits and wraps silently. It holds its value in IDLE until the next session starts.

## Timing

- Reset values: mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, rom_size=0, load_done=0, overflow=0, FIFO empty, state IDLE.
- Reset mid-session discards the FIFO and the pending byte. mem_req is 0 the cycle after resetn is sampled low.
- Byte to FIFO:
  - The odd byte is registered on the strobe edge and the entry is visible the next cycle.
  - mem_req rises 1 cycle after the push when the FIFO was empty (2 cycles after the strobe).
- Ack to next request: the pop happens on the ack edge, mem_req is low for 1 cycle, then high with the next entry.
- Simultaneous push and pop in one cycle are both honoured. A full FIFO with a simultaneous pop accepts the push (no overflow).
- A mode change and a byte strobe in the same cycle: the byte is ignored and FLUSH is entered.
- load_done asserts exactly once per session, the cycle after the last ack (or the cycle after FLUSH is entered if nothing is outstanding).
- mem_ack while mem_req=0 is ignored.

## Test plan

- **Mode 1, 4 bytes:** bytes 12,34,56,78 with ack 3 cycles after each req → writes (0x000000,0x1234,11), (0x000001,0x5678,11); rom_size=4; one load_done.
- **Odd length, mode 4:** bytes AA,BB,CC then mode 0 → writes (0x300000,0xAABB,11), (0x300001,0xCC00,10); rom_size=3.
- **Overflow:** mode 2 with ack withheld and 12 bytes → 4 words queued at 0x380000..3, words 5-6 dropped, overflow=1. Release ack → exactly 4 writes. The next session clears overflow.
- **Back-to-back:** mode 1 with ack tied to the cycle after req → every req acked, req low ≥1 cycle between words, addresses consecutive.
- **Reset mid-load:** resetn low for 1 cycle with 3 words queued → mem_req=0 next cycle, rom_size=0, no load_done, a new mode 1 load starts at address 0.
- **Mode 3 and direct switch:** bytes in mode 3 → no req. Then 1→4 with one byte pending → flush writes the pending byte at the mode-1 address with be=10, load_done pulses, and the mode-4 session starts at 0x300000.

Source files
------------

// File: rtl/romload_writer.sv
// romload_writer: packs the ROM-loading byte stream into big-endian 16-bit
// words and writes them to SDRAM through a req/ack port, with a small word
// FIFO in between to absorb SDRAM latency.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for rom_loading to select a load mode (1, 2 or 4)
//   S_LOAD  | accepting bytes, pairing them into words, queueing writes
//   S_FLUSH | pushing any odd final byte, draining the FIFO, then load_done
module romload_writer #(
  parameter logic [21:0] ROM_BASE     = 22'h000000,
  parameter logic [21:0] CARTRAM_BASE = 22'h380000,
  parameter logic [21:0] BIOS_BASE    = 22'h300000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic [22:0] rom_size,
  output logic        load_done,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;
  state_t state, state_nxt;

  logic [2:0]  mode_q;
  logic [21:0] wptr;
  logic [7:0]  hi_q;
  logic        pend_q;

  logic [21:0] fifo_addr [FIFO_DEPTH];
  logic [15:0] fifo_data [FIFO_DEPTH];
  logic [1:0]  fifo_be   [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic        mode_ok;
  logic [21:0] base_sel;
  logic        push_req, push, pop, full;
  logic [15:0] push_data;
  logic [1:0]  push_be;
  logic        byte_ok;

  assign mode_ok = (rom_loading == 3'd1) || (rom_loading == 3'd2) || (rom_loading == 3'd4);
  assign pop     = mem_req && mem_ack;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign full    = (count == DEPTH_C) && !pop;
  assign push    = push_req && !full;
  // A byte coinciding with a mode change is ignored.
  assign byte_ok = (state == S_LOAD) && (rom_loading == mode_q) && rom_do_valid;

  // Region base for the requested load mode.
  always_comb begin
    base_sel = ROM_BASE;
    case (rom_loading)
      3'd2:    base_sel = CARTRAM_BASE;
      3'd4:    base_sel = BIOS_BASE;
      default: base_sel = ROM_BASE;
    endcase
  end

  // Next state, FIFO push request and completion pulse.
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_data = {hi_q, rom_do};
    push_be   = 2'b11;
    load_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (mode_ok) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (rom_loading != mode_q) state_nxt = S_FLUSH;
        else if (rom_do_valid && pend_q) push_req = 1'b1;
      end
      S_FLUSH: begin
        if (pend_q) begin
          push_req  = 1'b1;
          push_data = {hi_q, 8'h00};
          push_be   = 2'b10;
        end else if (count == '0) begin
          // count==0 implies no request is outstanding
          load_done = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Session bookkeeping: mode, write pointer, byte pairing, size, overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q   <= 3'd0;
      wptr     <= 22'd0;
      hi_q     <= 8'd0;
      pend_q   <= 1'b0;
      rom_size <= 23'd0;
      overflow <= 1'b0;
    end else if (state == S_IDLE && mode_ok) begin
      mode_q   <= rom_loading;
      wptr     <= base_sel;
      pend_q   <= 1'b0;
      rom_size <= 23'd0;
      overflow <= 1'b0;
    end else if (byte_ok) begin
      rom_size <= rom_size + 23'd1;
      if (!pend_q) begin
        hi_q   <= rom_do;
        pend_q <= 1'b1;
      end else begin
        pend_q <= 1'b0;
        wptr   <= wptr + 22'd1;
        if (full) overflow <= 1'b1;
      end
    end else if (state == S_FLUSH && push) begin
      pend_q <= 1'b0;
    end
  end

  // FIFO storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wptr;
      fifo_data[wr_ptr] <= push_data;
      fifo_be[wr_ptr]   <= push_be;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write port: present the FIFO head, drop req for a cycle after each ack.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_addr  <= 22'd0;
      mem_wdata <= 16'd0;
      mem_be    <= 2'b00;
    end else if (pop) begin
      mem_req <= 1'b0;
    end else if (!mem_req && count != '0) begin
      mem_req   <= 1'b1;
      mem_addr  <= fifo_addr[rd_ptr];
      mem_wdata <= fifo_data[rd_ptr];
      mem_be    <= fifo_be[rd_ptr];
    end
  end

endmodule

// File: tb/tb_romload_writer.sv
// Bench for romload_writer: directed byte streams, expected SDRAM writes
// queued at stimulus time and checked by an independent write monitor.
module tb_romload_writer;

  logic        clk;
  logic        resetn;
  logic [2:0]  rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic        mem_req;
  logic        mem_ack;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic [22:0] rom_size;
  logic        load_done;
  logic        overflow;

  romload_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .rom_size     (rom_size),
    .load_done    (load_done),
    .overflow     (overflow)
  );

  typedef struct {
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  nvec = 0;
  int  nfail = 0;
  int  done_cnt = 0;
  int  req_cycles = 0;
  logic prev_ack = 1'b0;
  logic ack_block = 1'b0;
  int  ack_delay = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rom_do       = b;
    rom_do_valid = 1'b1;
    tick();
    rom_do_valid = 1'b0;
    tick();
  endtask

  task automatic expect_wr(input logic [21:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_t w;
    w.a  = a;
    w.d  = d;
    w.be = be;
    exp_q.push_back(w);
  endtask

  task automatic wait_done(input int base, input string nm);
    int n;
    n = 0;
    while (done_cnt == base && n < 500) begin
      tick();
      n++;
    end
    nvec++;
    if (done_cnt == base) begin
      nfail++;
      $display("FAIL %s: load_done not seen within 500 cycles (count %0d)", nm, done_cnt);
    end
  endtask

  // Ack responder: acks ack_delay cycles after req rises unless blocked.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    forever begin
      tick();
      mem_ack = 1'b0;
      if (mem_req && !ack_block) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Write monitor: pops the scoreboard on every accepted write.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_ack = 1'b0;
    end else begin
      if (prev_ack) begin
        nvec++;
        if (mem_req !== 1'b0) begin
          nfail++;
          $display("FAIL req_gap: mem_req %0b in cycle after ack, expected 0", mem_req);
        end
      end
      if (mem_req) req_cycles++;
      if (load_done) done_cnt++;
      if (mem_req && mem_ack) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_write: addr %06h data %04h be %02b, none expected",
                   mem_addr, mem_wdata, mem_be);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          if (mem_addr !== w.a || mem_wdata !== w.d || mem_be !== w.be) begin
            nfail++;
            $display("FAIL write: got addr %06h data %04h be %02b, expected addr %06h data %04h be %02b",
                     mem_addr, mem_wdata, mem_be, w.a, w.d, w.be);
          end
        end
      end
      prev_ack = mem_req && mem_ack;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rq;
    resetn       = 1'b0;
    rom_loading  = 3'd0;
    rom_do       = 8'h00;
    rom_do_valid = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    check("rst_mem_req",   32'(mem_req),   32'h0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_mem_be",    32'(mem_be),    32'h0);
    check("rst_rom_size",  32'(rom_size),  32'h0);
    check("rst_load_done", 32'(load_done), 32'h0);
    check("rst_overflow",  32'(overflow),  32'h0);

    // Mode 1, four bytes, slow acks
    ack_delay = 3;
    base = done_cnt;
    rom_loading = 3'd1;
    repeat (2) tick();
    expect_wr(22'h000000, 16'h1234, 2'b11);
    expect_wr(22'h000001, 16'h5678, 2'b11);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    rom_loading = 3'd0;
    wait_done(base, "m1_done");
    repeat (5) tick();
    check("m1_rom_size", 32'(rom_size), 32'd4);
    check("m1_done_once", 32'(done_cnt - base), 32'd1);
    check("m1_drained", 32'(exp_q.size()), 32'd0);

    // Mode 4, odd length
    ack_delay = 0;
    base = done_cnt;
    rom_loading = 3'd4;
    repeat (2) tick();
    expect_wr(22'h300000, 16'hAABB, 2'b11);
    expect_wr(22'h300001, 16'hCC00, 2'b10);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rom_loading = 3'd0;
    wait_done(base, "odd_done");
    repeat (5) tick();
    check("odd_rom_size", 32'(rom_size), 32'd3);
    check("odd_done_once", 32'(done_cnt - base), 32'd1);
    check("odd_drained", 32'(exp_q.size()), 32'd0);

    // Overflow: mode 2, ack withheld, 12 bytes -> 4 queued, 2 dropped
    ack_block = 1'b1;
    base = done_cnt;
    rom_loading = 3'd2;
    repeat (2) tick();
    expect_wr(22'h380000, 16'h0102, 2'b11);
    expect_wr(22'h380001, 16'h0304, 2'b11);
    expect_wr(22'h380002, 16'h0506, 2'b11);
    expect_wr(22'h380003, 16'h0708, 2'b11);
    for (int i = 1; i <= 12; i++) send_byte(8'(i));
    check("ovf_overflow", 32'(overflow), 32'h1);
    check("ovf_rom_size", 32'(rom_size), 32'd12);
    check("ovf_req_held", 32'(mem_req), 32'h1);
    rom_loading = 3'd0;
    ack_block = 1'b0;
    wait_done(base, "ovf_done");
    repeat (10) tick();
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Back-to-back, ack the cycle after req
    ack_delay = 1;
    base = done_cnt;
    rom_loading = 3'd1;
    repeat (2) tick();
    check("b2b_ovf_clear", 32'(overflow), 32'h0);
    expect_wr(22'h000000, 16'h1122, 2'b11);
    expect_wr(22'h000001, 16'h3344, 2'b11);
    expect_wr(22'h000002, 16'h5566, 2'b11);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    rom_loading = 3'd0;
    wait_done(base, "b2b_done");
    repeat (5) tick();
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_rom_size", 32'(rom_size), 32'd6);

    // Reset mid-load with three words queued
    ack_block = 1'b1;
    ack_delay = 0;
    rom_loading = 3'd1;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) send_byte(8'hA1 + 8'(i));
    check("rml_req_pending", 32'(mem_req), 32'h1);
    base = done_cnt;
    exp_q.delete();
    resetn = 1'b0;
    tick();
    check("rml_req_low", 32'(mem_req), 32'h0);
    check("rml_rom_size", 32'(rom_size), 32'd0);
    resetn = 1'b1;
    ack_block = 1'b0;
    repeat (2) tick();
    expect_wr(22'h000000, 16'h9ABC, 2'b11);
    send_byte(8'h9A); send_byte(8'hBC);
    rom_loading = 3'd0;
    wait_done(base, "rml_done");
    repeat (5) tick();
    check("rml_done_once", 32'(done_cnt - base), 32'd1);
    check("rml_drained", 32'(exp_q.size()), 32'd0);
    check("rml_rom_size2", 32'(rom_size), 32'd2);

    // Mode 3 ignores bytes
    rq = req_cycles;
    base = done_cnt;
    rom_loading = 3'd3;
    repeat (2) tick();
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("m3_no_req", 32'(req_cycles - rq), 32'd0);
    check("m3_rom_size_hold", 32'(rom_size), 32'd2);
    check("m3_no_done", 32'(done_cnt - base), 32'd0);

    // Direct switch 1 -> 4 with one byte pending
    rom_loading = 3'd1;
    repeat (2) tick();
    expect_wr(22'h000000, 16'h1122, 2'b11);
    expect_wr(22'h000001, 16'h3300, 2'b10);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rom_loading = 3'd4;
    wait_done(base, "sw_done");
    check("sw_rom_size", 32'(rom_size), 32'd3);
    repeat (3) tick();
    base = done_cnt;
    expect_wr(22'h300000, 16'h4455, 2'b11);
    send_byte(8'h44); send_byte(8'h55);
    rom_loading = 3'd0;
    wait_done(base, "sw4_done");
    repeat (5) tick();
    check("sw4_done_once", 32'(done_cnt - base), 32'd1);
    check("sw4_rom_size", 32'(rom_size), 32'd2);
    check("sw4_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
